// File: rtl/resilient_sample_reg.sv
// Timing-resilient stage register: captures d on clk, re-samples at the sample strobe and
// reports the comparison as a dual-rail return-to-zero code while forwarding the corrected value.
module resilient_sample_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] dout,
  output logic             Err1,
  output logic             Err0,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] q_d, q_q;
  logic [WIDTH-1:0] shadow_d, shadow_q;
  logic             mismatch_d, mismatch_q;
  logic             tog_p_d, tog_p_q;
  logic             tog_n_d, tog_n_q;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic             eval_valid;

  // Main (speculative) register
  always_comb begin
    q_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Evaluation state, updated on the rising edge of the detection window
  always_comb begin
    shadow_d   = d;
    mismatch_d = (d != q_q);
    tog_p_d    = ~tog_p_q;
    err_cnt_d  = err_cnt_q;
    if (mismatch_d && (err_cnt_q != CntMax)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sample or posedge rst) begin
    if (rst) begin
      shadow_q   <= '0;
      mismatch_q <= 1'b0;
      tog_p_q    <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      shadow_q   <= shadow_d;
      mismatch_q <= mismatch_d;
      tog_p_q    <= tog_p_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Return-to-null: the falling edge re-aligns the toggle pair so eval_valid drops
  always_comb begin
    tog_n_d = tog_p_q;
  end

  always_ff @(negedge sample or posedge rst) begin
    if (rst) begin
      tog_n_q <= 1'b0;
    end else begin
      tog_n_q <= tog_n_d;
    end
  end

  // Rails are pure functions of flop outputs; only one toggle flop changes per edge
  always_comb begin
    eval_valid = tog_p_q ^ tog_n_q;
    Err1       = eval_valid & mismatch_q;
    Err0       = eval_valid & ~mismatch_q;
    dout       = mismatch_q ? shadow_q : q_q;
    q          = q_q;
    err_cnt    = err_cnt_q;
  end

endmodule

// File: tb/tb_resilient_sample_reg.sv
// Randomized self-checking bench for resilient_sample_reg against a behavioural event model.
module tb_resilient_sample_reg;

  localparam int W = 8;
  localparam int C = 4;
  localparam int CMAX = (1 << C) - 1;

  logic         clk, rst, sample;
  logic [W-1:0] d, q, dout;
  logic         Err1, Err0;
  logic [C-1:0] err_cnt;

  resilient_sample_reg #(.WIDTH(W), .CNT_W(C)) dut (
    .clk     (clk),
    .rst     (rst),
    .sample  (sample),
    .d       (d),
    .q       (q),
    .dout    (dout),
    .Err1    (Err1),
    .Err0    (Err0),
    .err_cnt (err_cnt)
  );

  // Observed vector: {q, dout, err_cnt, Err1, Err0}
  logic [2*W+C+1:0] obs;
  assign obs = {q, dout, err_cnt, Err1, Err0};

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the register as seen by the controller
  logic [W-1:0] m_q, m_sh;
  bit           m_mm, m_ev;
  int           m_cnt;

  function automatic logic [2*W+C+1:0] expv();
    logic [C-1:0] c;
    c = C'(m_cnt);
    return {m_q, (m_mm ? m_sh : m_q), c, (m_ev && m_mm), (m_ev && !m_mm)};
  endfunction

  task automatic model_reset();
    m_q = '0; m_sh = '0; m_mm = 0; m_ev = 0; m_cnt = 0;
  endtask

  task automatic clk_pulse(input logic [W-1:0] v);
    d = v;
    #2 clk = 1'b1;
    m_q = v;
    #5 clk = 1'b0;
    #3;
  endtask

  task automatic rise();
    sample = 1'b1;
    m_sh = d;
    m_mm = (d != m_q);
    if (m_mm && m_cnt < CMAX) m_cnt = m_cnt + 1;
    m_ev = 1;
    #2;
  endtask

  task automatic fall();
    sample = 1'b0;
    m_ev = 0;
    #2;
  endtask

  function automatic logic [W-1:0] differ(input logic [W-1:0] a);
    return a ^ W'($urandom_range(1, (1 << W) - 1));
  endfunction

  task automatic test_reset();
    rst = 1'b1; sample = 1'b1; clk = 1'b0; d = '0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      d = W'($urandom);
      clk = 1'b1; #2;
      n_checks++;
      if (obs !== expv()) begin
        n_fail++; $display("FAIL reset_hold: got %h exp %h", obs, expv());
      end
      clk = 1'b0; #2;
    end
    rst = 1'b0; #2;
    clk_pulse(8'h11);
    n_checks++;
    if (obs !== expv() || Err1 !== 1'b0 || Err0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_rails: got %h exp %h", obs, expv());
    end
    fall();
    n_checks++;
    if (obs !== expv()) begin
      n_fail++; $display("FAIL reset_release_fall: got %h exp %h", obs, expv());
    end
  endtask

  task automatic test_clean();
    clk_pulse(8'h3C);
    d = 8'h55; #1; d = 8'h3C; #1;  // glitch inside the window must not matter
    rise();
    n_checks++;
    if (obs !== expv() || Err0 !== 1'b1 || Err1 !== 1'b0 || dout !== 8'h3C) begin
      n_fail++; $display("FAIL clean_rise: got %h exp %h", obs, expv());
    end
    fall();
    n_checks++;
    if (obs !== expv() || Err0 !== 1'b0) begin
      n_fail++; $display("FAIL clean_fall: got %h exp %h", obs, expv());
    end
  endtask

  task automatic test_error();
    clk_pulse(8'h3C);
    d = 8'hA5; #2;
    rise();
    n_checks++;
    if (obs !== expv() || Err1 !== 1'b1 || q !== 8'h3C || dout !== 8'hA5) begin
      n_fail++; $display("FAIL error_rise: got %h exp %h", obs, expv());
    end
    fall();
    n_checks++;
    if (obs !== expv() || dout !== 8'hA5 || {Err1, Err0} !== 2'b00) begin
      n_fail++; $display("FAIL error_fall: got %h exp %h", obs, expv());
    end
  endtask

  task automatic test_alternation();
    logic [W-1:0] v;
    bit           pat [3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      v = W'($urandom);
      clk_pulse(v);
      d = pat[i] ? differ(v) : v; #2;
      rise();
      n_checks++;
      if (obs !== expv() || Err1 !== pat[i] || Err0 !== !pat[i]) begin
        n_fail++; $display("FAIL alternation_rise%0d: got %h exp %h", i, obs, expv());
      end
      fall();
      n_checks++;
      if (obs !== expv()) begin
        n_fail++; $display("FAIL alternation_fall%0d: got %h exp %h", i, obs, expv());
      end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] v;
    rst = 1'b1; model_reset(); #2; rst = 1'b0; #2;
    for (int i = 0; i < 17; i++) begin
      v = W'($urandom);
      clk_pulse(v);
      d = differ(v); #2;
      rise();
      n_checks++;
      if (obs !== expv()) begin
        n_fail++; $display("FAIL saturation_rise%0d: got %h exp %h", i, obs, expv());
      end
      fall();
    end
    n_checks++;
    if (err_cnt !== 4'd15) begin
      n_fail++; $display("FAIL saturation_cnt: got %0d exp 15", err_cnt);
    end
    clk_pulse(8'h01);
    d = 8'h02; #2;
    rise();
    n_checks++;
    if (Err1 !== 1'b1 || err_cnt !== 4'd15) begin
      n_fail++; $display("FAIL saturation_err1: got Err1=%b cnt=%0d exp Err1=1 cnt=15", Err1, err_cnt);
    end
    fall();
  endtask

  task automatic test_mid_eval_reset();
    clk_pulse(8'h55);
    d = 8'hAA; #2;
    rise();
    n_checks++;
    if (obs !== expv() || Err1 !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_pre: got %h exp %h", obs, expv());
    end
    rst = 1'b1; model_reset(); #1;
    n_checks++;
    if (obs !== expv() || Err1 !== 1'b0 || dout !== '0 || err_cnt !== '0) begin
      n_fail++; $display("FAIL mid_reset_async: got %h exp %h", obs, expv());
    end
    #2 rst = 1'b0; #2;
    n_checks++;
    if (obs !== expv()) begin
      n_fail++; $display("FAIL mid_reset_release: got %h exp %h", obs, expv());
    end
    fall();
    n_checks++;
    if (obs !== expv()) begin
      n_fail++; $display("FAIL mid_reset_fall: got %h exp %h", obs, expv());
    end
    clk_pulse(8'h77);
    rise();
    n_checks++;
    if (obs !== expv() || Err0 !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_clean: got %h exp %h", obs, expv());
    end
    fall();
  endtask

  // Random pulses, some with a replay clk edge inside the window
  task automatic test_back_to_back();
    logic [W-1:0] v;
    for (int i = 0; i < 40; i++) begin
      v = W'($urandom);
      clk_pulse(v);
      if ($urandom_range(0, 1) == 1) d = differ(v);
      #2;
      rise();
      n_checks++;
      if (obs !== expv()) begin
        n_fail++; $display("FAIL random_rise%0d: got %h exp %h", i, obs, expv());
      end
      if ($urandom_range(0, 2) == 0) begin
        clk_pulse(W'($urandom));
        n_checks++;
        if (obs !== expv()) begin
          n_fail++; $display("FAIL random_replay%0d: got %h exp %h", i, obs, expv());
        end
      end
      fall();
      n_checks++;
      if (obs !== expv()) begin
        n_fail++; $display("FAIL random_fall%0d: got %h exp %h", i, obs, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_error();
    test_alternation();
    test_saturation();
    test_mid_eval_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
